// File: rtl/spi_slave_pkg.sv
// Shared constants for the SPI slave front end: default widths, FSM state codes
// and the command encodings carried in rx_data[9:8].
package spi_slave_pkg;

    localparam int SPI_DATA_W = 8;
    localparam int FRAME_W    = SPI_DATA_W + 2;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_CHK_CMD   = 3'd1;
    localparam state_t ST_WRITE     = 3'd2;
    localparam state_t ST_READ_ADD  = 3'd3;
    localparam state_t ST_READ_DATA = 3'd4;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_tx_serializer.sv
// MISO serialiser: captures one read byte on load and shifts it out MSB first,
// one bit per clock, returning MISO to 0 afterwards.
module spi_tx_serializer
    import spi_slave_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              abort,
    input  logic [DATA_W-1:0] tx_data,
    output logic              miso,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] sh_p0;
    logic [CNT_W-1:0]  cnt;

    assign busy = (cnt != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            miso <= 1'b0;
            cnt  <= '0;
        end else if (abort) begin
            miso <= 1'b0;
            cnt  <= '0;
        end else if (load) begin
            miso <= tx_data[DATA_W-1];
            cnt  <= CNT_W'(DATA_W - 1);
        end else if (busy) begin
            miso <= sh_p0[DATA_W-1];
            cnt  <= cnt - 1'b1;
        end else begin
            miso <= 1'b0;
        end
    end

    // The MSB goes straight to MISO at load time, so the shifter holds the rest.
    always_ff @(posedge clk) begin
        if (load) begin
            sh_p0 <= {tx_data[DATA_W-2:0], 1'b0};
        end else if (busy) begin
            sh_p0 <= {sh_p0[DATA_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/spi_slave.sv
// SPI slave front end: deserialises 10-bit command/data words from MOSI and
// returns RAM read data on MISO through spi_tx_serializer.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
);

    localparam int FW    = DATA_W + 2;
    localparam int CNT_W = $clog2(FW);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FW - 1);

    state_t          state;
    logic [CNT_W-1:0] bit_cnt;
    logic [FW-1:0]   shreg_p0;
    logic [FW-1:0]   word_nxt;
    logic            word_done;
    logic            tx_loaded;
    logic            rd_addr_seen;
    logic            in_word;
    logic            tx_load;
    logic            tx_busy;

    assign in_word = !SS_n && !word_done &&
                     ((state == ST_WRITE) || (state == ST_READ_ADD) ||
                      (state == ST_READ_DATA));

    assign word_nxt = {shreg_p0[FW-2:0], MOSI};

    // Only the first tx_valid after a completed READ_DATA word is accepted.
    assign tx_load = !SS_n && (state == ST_READ_DATA) && word_done &&
                     !tx_loaded && !tx_busy && tx_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            word_done    <= 1'b0;
            tx_loaded    <= 1'b0;
            rd_addr_seen <= 1'b0;
            rx_valid     <= 1'b0;
            rx_data      <= '0;
        end else begin
            rx_valid <= 1'b0;
            if (SS_n) begin
                state     <= ST_IDLE;
                bit_cnt   <= '0;
                word_done <= 1'b0;
                tx_loaded <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state     <= ST_CHK_CMD;
                        bit_cnt   <= '0;
                        word_done <= 1'b0;
                        tx_loaded <= 1'b0;
                    end
                    ST_CHK_CMD: begin
                        if (!MOSI) begin
                            state <= ST_WRITE;
                        end else if (rd_addr_seen) begin
                            state <= ST_READ_DATA;
                        end else begin
                            state <= ST_READ_ADD;
                        end
                    end
                    ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
                        if (in_word) begin
                            if (bit_cnt == LAST_BIT) begin
                                rx_data   <= word_nxt;
                                rx_valid  <= 1'b1;
                                word_done <= 1'b1;
                                bit_cnt   <= '0;
                                if (state == ST_READ_ADD) begin
                                    rd_addr_seen <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                        if (tx_load) begin
                            tx_loaded    <= 1'b1;
                            rd_addr_seen <= 1'b0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_word) begin
            shreg_p0 <= word_nxt;
        end
    end

    spi_tx_serializer #(
        .DATA_W (DATA_W)
    ) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tx_load),
        .abort   (SS_n),
        .tx_data (tx_data),
        .miso    (MISO),
        .busy    (tx_busy)
    );

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: directed and random frames checked against a frame-level
// model of the protocol (read-address flag, received word, expected MISO byte).
module tb_spi_slave;

    localparam int DATA_W = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int n_checks = 0;
    int n_pass   = 0;

    // Frame-level reference state
    bit         rd_flag;
    logic [9:0] last_word;

    always #5 clk = ~clk;

    spi_slave #(
        .DATA_W (DATA_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // abort_at: word bit index whose cycle sees SS_n high (-1 = none)
    // rst_at:   MISO bit index during which rst_n is pulled low (-1 = none)
    task automatic run_frame(input bit cmd, input logic [9:0] word, input int abort_at,
                             input int gap, input logic [7:0] d, input int rst_at);
        bit is_rd;
        SS_n     = 1'b0;
        tx_valid = 1'b0;
        MOSI     = 1'($urandom);
        step();
        MOSI = cmd;
        step();
        for (int i = 0; i < 10; i++) begin
            MOSI = word[9-i];
            if (i == abort_at) begin
                SS_n = 1'b1;
                step();
                chk("abort_vld", 32'(rx_valid), 32'd0);
                chk("abort_miso", 32'(MISO), 32'd0);
                step();
                chk("abort_vld2", 32'(rx_valid), 32'd0);
                chk("abort_hold", 32'(rx_data), 32'(last_word));
                return;
            end
            step();
            if (i < 9) begin
                chk("bit_vld", 32'(rx_valid), 32'd0);
            end
        end
        chk("rx_vld", 32'(rx_valid), 32'd1);
        chk("rx_data", 32'(rx_data), 32'(word));
        chk("rx_miso", 32'(MISO), 32'd0);
        last_word = word;
        is_rd = cmd && rd_flag;
        if (cmd && !rd_flag) rd_flag = 1'b1;

        MOSI = 1'($urandom);
        step();
        chk("vld_pulse", 32'(rx_valid), 32'd0);
        chk("rx_hold", 32'(rx_data), 32'(word));
        for (int g = 0; g < gap; g++) begin
            MOSI = 1'($urandom);
            step();
            chk("gap_miso", 32'(MISO), 32'd0);
        end

        tx_valid = 1'b1;
        tx_data  = d;
        step();
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        if (is_rd) begin
            for (int k = 7; k >= 0; k--) begin
                chk("miso_bit", 32'(MISO), 32'(d[k]));
                if (k == rst_at) begin
                    rst_n = 1'b0;
                    step();
                    chk("rst_miso", 32'(MISO), 32'd0);
                    chk("rst_vld", 32'(rx_valid), 32'd0);
                    chk("rst_data", 32'(rx_data), 32'd0);
                    rd_flag   = 1'b0;
                    last_word = '0;
                    rst_n     = 1'b1;
                    SS_n      = 1'b1;
                    step();
                    return;
                end
                tx_valid = 1'($urandom);
                step();
                tx_valid = 1'b0;
            end
            rd_flag = 1'b0;
        end else begin
            for (int k = 0; k < 9; k++) begin
                chk("no_miso", 32'(MISO), 32'd0);
                step();
            end
        end
        chk("miso_tail", 32'(MISO), 32'd0);
        SS_n = 1'b1;
        step();
        chk("end_miso", 32'(MISO), 32'd0);
        chk("end_vld", 32'(rx_valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        SS_n      = 1'b1;
        MOSI      = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        rd_flag   = 1'b0;
        last_word = '0;
        step();
        step();
        chk("rst_miso0", 32'(MISO), 32'd0);
        chk("rst_vld0", 32'(rx_valid), 32'd0);
        chk("rst_data0", 32'(rx_data), 32'd0);
        rst_n = 1'b1;
        step();

        run_frame(1'b0, 10'h03A, -1, 1, 8'h5A, -1);
        run_frame(1'b0, 10'h1C5, -1, 0, 8'hC3, -1);
        run_frame(1'b1, 10'h23A, -1, 0, 8'h11, -1);
        run_frame(1'b1, 10'h300, -1, 0, 8'hA5, -1);
        // Flag consumed above: this read goes to READ_ADD, then a real read follows
        run_frame(1'b1, 10'h2F0, -1, 2, 8'hFF, -1);
        run_frame(1'b1, 10'h3C1, -1, 3, 8'h3C, -1);
        // Abort mid-word, then a clean frame
        run_frame(1'b0, 10'h155, 5, 0, 8'h00, -1);
        run_frame(1'b0, 10'h0FF, -1, 0, 8'h00, -1);
        // SS_n rising with the 10th bit must not complete READ_ADD
        run_frame(1'b1, 10'h2AA, 9, 0, 8'h00, -1);
        run_frame(1'b1, 10'h2AB, -1, 1, 8'h81, -1);
        // Reset during MISO bit 4; the next read must start with READ_ADD again
        run_frame(1'b1, 10'h3F0, -1, 1, 8'hB6, 4);
        run_frame(1'b1, 10'h2CC, -1, 0, 8'h77, -1);
        run_frame(1'b1, 10'h3CC, -1, 0, 8'h96, -1);

        for (int r = 0; r < 40; r++) begin
            int ab;
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 9)) : -1;
            run_frame(1'($urandom), 10'($urandom), ab, int'($urandom_range(0, 3)),
                      8'($urandom), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
# spi_slave

Serial front end of the SPI slave subsystem. Deserialises MOSI frames into 10-bit command/data words for the on-chip RAM (rx_data/rx_valid) and serialises the RAM's 8-bit read response (tx_data/tx_valid) back onto MISO. SPI bit timing is carried by the system clock; MOSI is sampled and MISO updated on posedge clk while SS_n is low.

## Interface
- DATA_W, 8: RAM data width; rx word width is DATA_W+2 (2 command bits + payload).
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- SS_n  in  1  slave select, active low; high aborts/ends a frame.
- MOSI  in  1  serial data in, MSB first.
- MISO  out  1  serial data out, MSB first.
- rx_data  out  DATA_W+2  deserialised word; [9:8] command, [7:0] payload.
- rx_valid  out  1  one-cycle strobe, rx_data valid.
- tx_data  in  DATA_W  read data from RAM.
- tx_valid  in  1  tx_data valid strobe from RAM.

## Operation
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: SS_n low → CHK_CMD.
- CHK_CMD: samples MOSI as command bit (not stored). 0 → WRITE; 1 and rd_addr_seen=0 → READ_ADD; 1 and rd_addr_seen=1 → READ_DATA.
- WRITE / READ_ADD / READ_DATA: shift 10 MOSI bits MSB first into shift register (bit count 0..9). After 10th bit, rx_data loads the word, rx_valid asserts one cycle. Further MOSI bits in the frame ignored.
- READ_ADD: rx_valid sets rd_addr_seen.
- READ_DATA: after rx_valid, waits for tx_valid; on tx_valid captures tx_data, then drives MISO with bits 7..0 on 8 consecutive cycles, then MISO=0; clears rd_addr_seen. tx_valid outside READ_DATA-wait ignored.
- Command bits inside rx_data come from MOSI unmodified; no decoding of [9:8] here (RAM decodes).
- SS_n high in any state → IDLE next cycle; bit counters clear; partial word discarded (no rx_valid); MISO=0; rd_addr_seen kept.
- rx_data holds last completed word until next completion.

## Timing
- Reset values: MISO=0, rx_valid=0, rx_data=0, state IDLE, rd_addr_seen=0, counters 0.
- Reset mid-frame: all of above on next edge; frame lost.
- Cycle n: SS_n sampled low (IDLE→CHK_CMD). n+1: command bit. n+2..n+11: 10 word bits. n+12: rx_valid=1, rx_data valid.
- RAM returns tx_valid at earliest n+13; if tx_valid sampled at cycle t, MISO=tx_data[7] during t+1, tx_data[0] during t+8.
- Back-to-back frames need SS_n high for ≥1 cycle.
- SS_n rising on same edge as 10th bit: word discarded, no rx_valid.

## Structure
- spi_slave_pkg: state enum, DATA_W default, FRAME_W = DATA_W+2, command bit constants (CMD_WR_ADDR 2'b00, CMD_WR_DATA 2'b01, CMD_RD_ADDR 2'b10, CMD_RD_DATA 2'b11).
- One sub-module natural: spi_tx_serializer (load on tx_valid, 8-bit shift, busy flag, MISO drive).

## Test plan
- Write address: SS_n low, cmd 0, word 10'h03A → rx_data=10'h03A, rx_valid one cycle at n+12, MISO stays 0.
- Write data: cmd 0, word 10'h1C5 → rx_data=10'h1C5, rx_valid pulse; rd_addr_seen unchanged.
- Read pair: cmd 1, word 10'h23A (state READ_ADD, flag set); next frame cmd 1, word 10'h300 → READ_DATA, rx_valid; tx_valid with tx_data=8'hA5 → MISO 1,0,1,0,0,1,0,1 over next 8 cycles; flag cleared.
- Read data without prior address: after reset, cmd 1 → READ_ADD taken, no MISO activity even if tx_valid pulses.
- Abort: SS_n high after 5 word bits → no rx_valid, IDLE next cycle; following full frame 10'h0FF received correctly.
- Reset mid-serialisation: rst_n low during MISO bit 4 → MISO=0, rx_valid=0, rx_data=0, IDLE next edge; new read requires READ_ADD again.
